// File: rtl/key_expansion_inv.sv
// key_expansion_inv: iterative AES-128 inverse key schedule.
// Loads the round-10 key and emits round keys 10 down to 0, one per clock.
// Optional build macro KEYINV_FWD_PRELOAD_EN: key inputs carry the cipher key,
// which is first run forward to round 10 (state PRE), then backward as usual.
//
// Ports
//   CLK                 rising-edge clock
//   RST                 asynchronous active-low reset
//   start_in            start request, sampled on rising CLK edges
//   key0_in..key3_in    key words (MSB = first byte)
//   key0_out..key3_out  current round key words w[4r]..w[4r+3], registered
//   round_out           round index r of key*_out, registered
//   state_out           00 IDLE, 01 RUN, 10 DONE, 11 PRE (macro builds only)
module key_expansion_inv (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_in,
  input  logic [31:0] key0_in,
  input  logic [31:0] key1_in,
  input  logic [31:0] key2_in,
  input  logic [31:0] key3_in,
  output logic [31:0] key0_out,
  output logic [31:0] key1_out,
  output logic [31:0] key2_out,
  output logic [31:0] key3_out,
  output logic [3:0]  round_out,
  output logic [1:0]  state_out
);

`ifdef KEYINV_FWD_PRELOAD_EN
  typedef enum logic [1:0] {StIdle = 2'b00, StRun = 2'b01, StDone = 2'b10, StPre = 2'b11} state_e;
`else
  typedef enum logic [1:0] {StIdle = 2'b00, StRun = 2'b01, StDone = 2'b10} state_e;
`endif

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  logic [31:0] w0_q, w1_q, w2_q, w3_q, w0_d, w1_d, w2_d, w3_d;
  logic [3:0]  round_q, round_d;
  state_e      state_q, state_d;
  // Blocks start on the first edge after reset release.
  logic        armed_q;

  logic [31:0] sbox_in, rot, g;
  logic [3:0]  rcon_idx;
  logic [31:0] b0, b1, b2, b3;

  always_comb begin
    sbox_in  = w3_q ^ w2_q;
    rcon_idx = round_q;
`ifdef KEYINV_FWD_PRELOAD_EN
    // Forward step shares the S-boxes: it feeds w3 and uses Rcon[round+1].
    if (state_q == StPre) begin
      sbox_in  = w3_q;
      rcon_idx = round_q + 4'd1;
    end
`endif
    rot = {sbox_in[23:0], sbox_in[31:24]};
    g   = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
          ^ {rcon(rcon_idx), 24'h0};
    b3  = w3_q ^ w2_q;
    b2  = w2_q ^ w1_q;
    b1  = w1_q ^ w0_q;
    b0  = w0_q ^ g;
  end

`ifdef KEYINV_FWD_PRELOAD_EN
  logic [31:0] f0, f1, f2, f3;
  always_comb begin
    f0 = w0_q ^ g;
    f1 = w1_q ^ f0;
    f2 = w2_q ^ f1;
    f3 = w3_q ^ f2;
  end
`endif

  always_comb begin
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    round_d = round_q;
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_in && armed_q) begin
          w0_d = key0_in;
          w1_d = key1_in;
          w2_d = key2_in;
          w3_d = key3_in;
`ifdef KEYINV_FWD_PRELOAD_EN
          round_d = 4'd0;
          state_d = StPre;
`else
          round_d = 4'd10;
          state_d = StRun;
`endif
        end
      end
      StRun: begin
        w0_d = b0;
        w1_d = b1;
        w2_d = b2;
        w3_d = b3;
        if (round_q <= 4'd1) begin
          round_d = 4'd0;
          state_d = StDone;
        end else begin
          round_d = round_q - 4'd1;
        end
      end
`ifdef KEYINV_FWD_PRELOAD_EN
      StPre: begin
        w0_d = f0;
        w1_d = f1;
        w2_d = f2;
        w3_d = f3;
        if (round_q >= 4'd9) begin
          round_d = 4'd10;
          state_d = StRun;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      round_q <= '0;
      state_q <= StIdle;
      armed_q <= 1'b0;
    end else begin
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      round_q <= round_d;
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  assign key0_out  = w0_q;
  assign key1_out  = w1_q;
  assign key2_out  = w2_q;
  assign key3_out  = w3_q;
  assign round_out = round_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_key_expansion_inv.sv
// Bench for key_expansion_inv: directed FIPS-197 / team vectors plus random keys
// checked against a forward key-expansion model whose S-box is derived from
// GF(2^8) inversion and the affine map.
module tb_key_expansion_inv;

  logic        clk, rst_n, start_in;
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] o0, o1, o2, o3;
  logic [3:0]  round_out;
  logic [1:0]  state_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  sbox [256];
  logic [31:0] ref_w [44];

  key_expansion_inv dut (
    .CLK      (clk),
    .RST      (rst_n),
    .start_in (start_in),
    .key0_in  (k0),
    .key1_in  (k1),
    .key2_in  (k2),
    .key3_in  (k3),
    .key0_out (o0),
    .key1_out (o1),
    .key2_out (o2),
    .key3_out (o3),
    .round_out(round_out),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  // Forward AES-128 key expansion of a cipher key into ref_w[0..43].
  task automatic expand(input logic [127:0] key);
    logic [7:0]  rc;
    logic [31:0] t;
    for (int i = 0; i < 4; i++) ref_w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = ref_w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      ref_w[i] = ref_w[i-4] ^ t;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [127:0] exp_key, input int r,
                           input logic [1:0] st);
    check({tag, " key0"}, o0, exp_key[127:96]);
    check({tag, " key1"}, o1, exp_key[95:64]);
    check({tag, " key2"}, o2, exp_key[63:32]);
    check({tag, " key3"}, o3, exp_key[31:0]);
    check({tag, " round"}, {28'h0, round_out}, 32'(r));
    check({tag, " state"}, {30'h0, state_out}, {30'h0, st});
  endtask

  function automatic logic [127:0] model_key(input int r);
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

  task automatic set_key(input logic [127:0] v);
    {k0, k1, k2, k3} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full run against the model for a given cipher key; start_in held at 'hold' after E.
  task automatic run_model(input string tag, input logic [127:0] cipher, input logic hold);
    expand(cipher);
`ifdef KEYINV_FWD_PRELOAD_EN
    set_key(cipher);
`else
    set_key(model_key(10));
`endif
    start_in = 1'b1;
    step();
    start_in = hold;
`ifdef KEYINV_FWD_PRELOAD_EN
    check_all({tag, " pre0"}, model_key(0), 0, 2'b11);
    for (int r = 1; r < 10; r++) begin
      step();
      check_all($sformatf("%s pre%0d", tag, r), model_key(r), r, 2'b11);
    end
    step();
`endif
    check_all({tag, " r10"}, model_key(10), 10, 2'b01);
    for (int r = 9; r >= 0; r--) begin
      step();
      check_all($sformatf("%s r%0d", tag, r), model_key(r), r, (r == 0) ? 2'b10 : 2'b01);
    end
    if (hold) begin
      step();
`ifdef KEYINV_FWD_PRELOAD_EN
      check_all({tag, " reload"}, cipher, 0, 2'b11);
`else
      check_all({tag, " reload"}, model_key(10), 10, 2'b01);
`endif
    end
    start_in = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start_in = 1'b0;
    set_key('0);
    build_sbox();
    #12;
    check_all("reset", '0, 0, 2'b00);
    // Start already high before release must not be taken on the release edge.
    start_in = 1'b1;
    #1 rst_n = 1'b1;
    step();
    check({"release state"}, {30'h0, state_out}, 32'h0);
    check({"release round"}, {28'h0, round_out}, 32'h0);
    start_in = 1'b0;
    step();

`ifndef KEYINV_FWD_PRELOAD_EN
    // FIPS-197 backward run.
    set_key(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    check_all("fips r10", 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 10, 2'b01);
    step();
    check_all("fips r9", 128'hac7766f3_19fadc21_28d12941_575c006e, 9, 2'b01);
    for (int r = 8; r >= 0; r--) step();
    check_all("fips r0", 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 0, 2'b10);

    // Team vector with a start pulse and garbage key inputs at E+4.
    expand(128'h54686174_73206d79_204b756e_67204675);
    set_key(128'h28fddef8_6da4244a_ccc0a4fe_3b316f26);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int r = 9; r >= 0; r--) begin
      if (r == 6) begin
        start_in = 1'b1;
        set_key({$urandom, $urandom, $urandom, $urandom});
      end else begin
        start_in = 1'b0;
      end
      step();
      check_all($sformatf("team r%0d", r), model_key(r), r, (r == 0) ? 2'b10 : 2'b01);
    end
    check_all("team const r0", 128'h54686174_73206d79_204b756e_67204675, 0, 2'b10);
    step();
    check_all("done hold", 128'h54686174_73206d79_204b756e_67204675, 0, 2'b10);
    set_key(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    check_all("done reload", 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 10, 2'b01);
    for (int r = 9; r >= 0; r--) step();
`else
    // Forward preload from the FIPS-197 cipher key.
    set_key(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    for (int i = 1; i < 10; i++) begin
      step();
      check($sformatf("fips pre state e%0d", i), {30'h0, state_out}, 32'h3);
    end
    step();
    check_all("fips pre r10", 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 10, 2'b01);
    for (int r = 9; r >= 0; r--) step();
    check_all("fips pre r0", 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 0, 2'b10);
`endif

    for (int n = 0; n < 5; n++)
      run_model($sformatf("rand%0d", n), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    run_model("hold", {$urandom, $urandom, $urandom, $urandom}, 1'b1);

    // Asynchronous reset in the middle of a sequence, away from any clock edge.
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_all("mid reset", '0, 0, 2'b00);
    #2 rst_n = 1'b1;
    step();
    check_all("after reset", '0, 0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
